reorder_buffer: RTL and testbench

Circular reorder buffer (ROB) for the out-of-order RISC-V core.
- Allocates one entry per dispatched instruction and returns its tag, which the register file records as the rename tag.
- Captures results broadcast on the CDB and serves operand-forwarding queries from Dispatch.
- Retires at most one entry per cycle, in order. Retirement drives the register-file commit port (`ROB_write_S`/`ROB_rd`/`ROB_Reorder`/`ROB_result`) and store release.
- Raises the pipeline-wide flush `clr` on a branch mispredict.

---
 rtl/reorder_buffer_pkg.sv | 64 ++++++
 rtl/reorder_buffer_if.sv | 59 +++++
 rtl/reorder_buffer.sv | 181 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: geometry, instruction classes,
// the per-entry payload record and the commit decode helpers.
package reorder_buffer_pkg;

   localparam int ROB_SIZE = 32;
   localparam int TAG_W    = $clog2(ROB_SIZE);

   typedef logic [TAG_W-1:0] rob_tag_t;
   typedef logic [TAG_W:0]   rob_count_t;

   // Instruction class recorded at dispatch.
   typedef enum logic [1:0] {
      TYPE_ALU    = 2'd0,  // ALU op or load
      TYPE_STORE  = 2'd1,
      TYPE_BRANCH = 2'd2,
      TYPE_JUMP   = 2'd3   // jal / jalr
   } rob_type_e;

   // Payload of one entry. Dispatch fills kind/rd/pc/pred,
   // the CDB fills value/taken/target.
   typedef struct packed {
      rob_type_e   kind;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        pred;
      logic [31:0] value;
      logic        taken;
      logic [31:0] target;
   } rob_entry_t;

   // What retiring one entry does to the rest of the core.
   typedef struct packed {
      logic        reg_write;
      logic        store_release;
      logic        flush;
      logic [31:0] redirect_pc;
   } rob_commit_t;

   // Decode the side effects of retiring entry e.
   function automatic rob_commit_t decode_commit(input rob_entry_t e);
      rob_commit_t c;
      c = '0;
      unique case (e.kind)
         TYPE_ALU: begin
            c.reg_write = (e.rd != 5'd0);
         end
         TYPE_STORE: begin
            c.store_release = 1'b1;
         end
         TYPE_BRANCH: begin
            c.flush       = (e.taken != e.pred);
            c.redirect_pc = e.taken ? e.target : 32'(e.pc + 32'd4);
         end
         TYPE_JUMP: begin
            c.reg_write   = (e.rd != 5'd0);
            c.flush       = (e.taken != e.pred);
            c.redirect_pc = e.target;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bus between the reorder buffer and its neighbours: dispatch allocation,
// operand queries, CDB writeback and the commit/flush outputs.
// The master side (dispatch, execution units, bench) drives requests;
// the slave side is the reorder buffer itself.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   // Dispatch allocation
   logic        Dispatch_alloc_S;
   rob_type_e   Dispatch_type;
   logic [4:0]  Dispatch_rd;
   logic [31:0] Dispatch_pc;
   logic        Dispatch_pred_taken;
   logic        ROB_full;
   rob_tag_t    ROB_free_pos;

   // Operand forwarding queries
   rob_tag_t    Query1_pos;
   rob_tag_t    Query2_pos;
   logic        Query1_ready;
   logic        Query2_ready;
   logic [31:0] Query1_value;
   logic [31:0] Query2_value;

   // Common data bus writeback
   logic        CDB_S;
   rob_tag_t    CDB_Reorder;
   logic [31:0] CDB_value;
   logic        CDB_taken;
   logic [31:0] CDB_target;

   // Commit, store release and flush
   logic        ROB_write_S;
   logic [4:0]  ROB_rd;
   rob_tag_t    ROB_Reorder;
   logic [31:0] ROB_result;
   logic        ROB_store_S;
   logic        clr;
   logic [31:0] clr_pc;

   modport master (
      output Dispatch_alloc_S, Dispatch_type, Dispatch_rd, Dispatch_pc, Dispatch_pred_taken,
      input  ROB_full, ROB_free_pos,
      output Query1_pos, Query2_pos,
      input  Query1_ready, Query2_ready, Query1_value, Query2_value,
      output CDB_S, CDB_Reorder, CDB_value, CDB_taken, CDB_target,
      input  ROB_write_S, ROB_rd, ROB_Reorder, ROB_result, ROB_store_S, clr, clr_pc
   );

   modport slave (
      input  Dispatch_alloc_S, Dispatch_type, Dispatch_rd, Dispatch_pc, Dispatch_pred_taken,
      output ROB_full, ROB_free_pos,
      input  Query1_pos, Query2_pos,
      output Query1_ready, Query2_ready, Query1_value, Query2_value,
      input  CDB_S, CDB_Reorder, CDB_value, CDB_taken, CDB_target,
      output ROB_write_S, ROB_rd, ROB_Reorder, ROB_result, ROB_store_S, clr, clr_pc
   );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer. Allocates entries in program order at the tail,
// captures CDB results out of order, retires one ready entry per cycle from
// the head and raises a one-cycle flush on a branch/jump mispredict.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   reorder_buffer_if.slave  rob
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   rob_tag_t            head_q;
   rob_tag_t            tail_q;
   rob_count_t          count_q;
   logic [ROB_SIZE-1:0] valid_q;
   logic [ROB_SIZE-1:0] ready_q;
   rob_entry_t          entry_q [ROB_SIZE];

   // Registered commit outputs
   logic        write_q;
   logic [4:0]  rd_q;
   rob_tag_t    reorder_q;
   logic [31:0] result_q;
   logic        store_q;
   logic        clr_q;
   logic [31:0] clr_pc_q;

   // Per-cycle decisions
   logic        full;
   logic        alloc_en;
   logic        wb_en;
   logic        commit_en;
   rob_entry_t  head_entry;
   rob_commit_t commit_info;

   // ---------------------------------------------------------------------
   // Control: which of allocate / writeback / commit happen this cycle.
   // During a flush cycle every request is dropped.
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      full        = (count_q == rob_count_t'(ROB_SIZE));
      head_entry  = entry_q[head_q];
      commit_info = decode_commit(head_entry);
      alloc_en    = 1'b0;
      wb_en       = 1'b0;
      commit_en   = 1'b0;
      if (!clr_q) begin
         // Full is taken from the count before this cycle's commit, so a
         // slot freed by the retiring entry is not reusable until next cycle.
         alloc_en  = rob.Dispatch_alloc_S && !full;
         wb_en     = rob.CDB_S && valid_q[rob.CDB_Reorder];
         commit_en = (count_q != '0) && valid_q[head_q] && ready_q[head_q];
      end
   end

   // ---------------------------------------------------------------------
   // Pointers, count and per-entry valid/ready flags.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         ready_q <= '0;
      end else if (rdy) begin
         if (clr_q) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
         end else begin
            if (alloc_en) begin
               valid_q[tail_q] <= 1'b1;
               ready_q[tail_q] <= 1'b0;
               tail_q          <= tail_q + 1'b1;
            end
            if (wb_en) begin
               ready_q[rob.CDB_Reorder] <= 1'b1;
            end
            // Retirement is last so it wins over a late writeback to head.
            if (commit_en) begin
               valid_q[head_q] <= 1'b0;
               ready_q[head_q] <= 1'b0;
               head_q          <= head_q + 1'b1;
            end
            unique case ({alloc_en, commit_en})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Entry payload storage: dispatch fields on allocate, results on CDB.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: the payload array is deliberately not reset; valid_q gates
      // every use, so clearing the flags is enough and keeps this a RAM.
      if (rdy && !clr_q) begin
         if (alloc_en) begin
            entry_q[tail_q].kind <= rob.Dispatch_type;
            entry_q[tail_q].rd   <= rob.Dispatch_rd;
            entry_q[tail_q].pc   <= rob.Dispatch_pc;
            entry_q[tail_q].pred <= rob.Dispatch_pred_taken;
         end
         if (wb_en) begin
            entry_q[rob.CDB_Reorder].value  <= rob.CDB_value;
            entry_q[rob.CDB_Reorder].taken  <= rob.CDB_taken;
            entry_q[rob.CDB_Reorder].target <= rob.CDB_target;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Commit outputs: pulses for exactly one cycle after the retiring edge;
   // data fields hold the last retired entry. A mispredicting jump raises
   // its register write together with clr.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         write_q   <= 1'b0;
         rd_q      <= '0;
         reorder_q <= '0;
         result_q  <= '0;
         store_q   <= 1'b0;
         clr_q     <= 1'b0;
         clr_pc_q  <= '0;
      end else if (rdy) begin
         write_q <= commit_en && commit_info.reg_write;
         store_q <= commit_en && commit_info.store_release;
         clr_q   <= commit_en && commit_info.flush;
         if (commit_en) begin
            rd_q      <= head_entry.rd;
            reorder_q <= head_q;
            result_q  <= head_entry.value;
            if (commit_info.flush) begin
               clr_pc_q <= commit_info.redirect_pc;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Operand queries: an entry is ready if its result is stored or is on
   // the CDB this very cycle; invalid entries never report ready.
   // ---------------------------------------------------------------------
   always_comb begin
      logic hit1;
      logic hit2;
      hit1 = rob.CDB_S && (rob.CDB_Reorder == rob.Query1_pos);
      hit2 = rob.CDB_S && (rob.CDB_Reorder == rob.Query2_pos);
      rob.Query1_ready = valid_q[rob.Query1_pos] && (ready_q[rob.Query1_pos] || hit1);
      rob.Query2_ready = valid_q[rob.Query2_pos] && (ready_q[rob.Query2_pos] || hit2);
      rob.Query1_value = hit1 ? rob.CDB_value : entry_q[rob.Query1_pos].value;
      rob.Query2_value = hit2 ? rob.CDB_value : entry_q[rob.Query2_pos].value;
   end

   // Status and commit outputs
   assign rob.ROB_full     = full;
   assign rob.ROB_free_pos = tail_q;
   assign rob.ROB_write_S  = write_q;
   assign rob.ROB_rd       = rd_q;
   assign rob.ROB_Reorder  = reorder_q;
   assign rob.ROB_result   = result_q;
   assign rob.ROB_store_S  = store_q;
   assign rob.clr          = clr_q;
   assign rob.clr_pc       = clr_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, away from the edge.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic clk;
   logic rst;
   logic rdy;
   int   checks;
   int   errors;

   reorder_buffer_if rob_bus ();

   reorder_buffer dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .rob (rob_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Run-time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rob_bus.Dispatch_alloc_S    = 1'b0;
      rob_bus.Dispatch_type       = TYPE_ALU;
      rob_bus.Dispatch_rd         = '0;
      rob_bus.Dispatch_pc         = '0;
      rob_bus.Dispatch_pred_taken = 1'b0;
      rob_bus.Query1_pos          = '0;
      rob_bus.Query2_pos          = '0;
      rob_bus.CDB_S               = 1'b0;
      rob_bus.CDB_Reorder         = '0;
      rob_bus.CDB_value           = '0;
      rob_bus.CDB_taken           = 1'b0;
      rob_bus.CDB_target          = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rdy = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc(input rob_type_e kind, input logic [4:0] rd,
                        input logic [31:0] pc, input logic pred);
      rob_bus.Dispatch_alloc_S    = 1'b1;
      rob_bus.Dispatch_type       = kind;
      rob_bus.Dispatch_rd         = rd;
      rob_bus.Dispatch_pc         = pc;
      rob_bus.Dispatch_pred_taken = pred;
      tick();
      rob_bus.Dispatch_alloc_S    = 1'b0;
   endtask

   task automatic cdb(input rob_tag_t tag, input logic [31:0] value,
                      input logic taken, input logic [31:0] target);
      rob_bus.CDB_S       = 1'b1;
      rob_bus.CDB_Reorder = tag;
      rob_bus.CDB_value   = value;
      rob_bus.CDB_taken   = taken;
      rob_bus.CDB_target  = target;
      tick();
      rob_bus.CDB_S       = 1'b0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (rob_bus.ROB_full !== 1'b0) begin
         errors++; $display("FAIL reset_full: got %b expected 0", rob_bus.ROB_full);
      end
      checks++;
      if (rob_bus.ROB_free_pos !== 5'd0) begin
         errors++; $display("FAIL reset_free_pos: got %0d expected 0", rob_bus.ROB_free_pos);
      end
      checks++;
      if ({rob_bus.ROB_write_S, rob_bus.ROB_store_S, rob_bus.clr} !== 3'b000) begin
         errors++; $display("FAIL reset_pulses: got %b expected 000",
                            {rob_bus.ROB_write_S, rob_bus.ROB_store_S, rob_bus.clr});
      end
      checks++;
      if ({rob_bus.ROB_rd, rob_bus.ROB_Reorder, rob_bus.ROB_result, rob_bus.clr_pc} !== '0) begin
         errors++; $display("FAIL reset_data: rd=%0d tag=%0d result=%h clr_pc=%h expected all 0",
                            rob_bus.ROB_rd, rob_bus.ROB_Reorder, rob_bus.ROB_result, rob_bus.clr_pc);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_in_order_commit();
      do_reset();
      alloc(TYPE_ALU, 5'd1, 32'h0, 1'b0);
      alloc(TYPE_ALU, 5'd2, 32'h4, 1'b0);
      alloc(TYPE_ALU, 5'd3, 32'h8, 1'b0);
      checks++;
      if (rob_bus.ROB_free_pos !== 5'd3) begin
         errors++; $display("FAIL inorder_free_pos: got %0d expected 3", rob_bus.ROB_free_pos);
      end
      cdb(5'd1, 32'd5, 1'b0, 32'h0);
      checks++;
      if (rob_bus.ROB_write_S !== 1'b0) begin
         errors++; $display("FAIL inorder_no_early_commit_a: write=%b expected 0", rob_bus.ROB_write_S);
      end
      cdb(5'd0, 32'd7, 1'b0, 32'h0);
      checks++;
      if (rob_bus.ROB_write_S !== 1'b0) begin
         errors++; $display("FAIL inorder_no_wb_bypass: write=%b expected 0", rob_bus.ROB_write_S);
      end
      tick();
      checks++;
      if ({rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_Reorder, rob_bus.ROB_result}
          !== {1'b1, 5'd1, 5'd0, 32'd7}) begin
         errors++; $display("FAIL inorder_commit0: write=%b rd=%0d tag=%0d result=%0d expected 1/1/0/7",
                            rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_Reorder, rob_bus.ROB_result);
      end
      tick();
      checks++;
      if ({rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_Reorder, rob_bus.ROB_result}
          !== {1'b1, 5'd2, 5'd1, 32'd5}) begin
         errors++; $display("FAIL inorder_commit1: write=%b rd=%0d tag=%0d result=%0d expected 1/2/1/5",
                            rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_Reorder, rob_bus.ROB_result);
      end
      tick();
      checks++;
      if (rob_bus.ROB_write_S !== 1'b0) begin
         errors++; $display("FAIL inorder_pulse_one_cycle: write=%b expected 0", rob_bus.ROB_write_S);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < ROB_SIZE; i++) begin
         alloc(TYPE_ALU, 5'd0, 32'(i * 4), 1'b0);
      end
      checks++;
      if ({rob_bus.ROB_full, rob_bus.ROB_free_pos} !== {1'b1, 5'd0}) begin
         errors++; $display("FAIL full_after_32: full=%b free_pos=%0d expected 1/0",
                            rob_bus.ROB_full, rob_bus.ROB_free_pos);
      end
      alloc(TYPE_ALU, 5'd9, 32'h80, 1'b0);
      checks++;
      if ({rob_bus.ROB_full, rob_bus.ROB_free_pos} !== {1'b1, 5'd0}) begin
         errors++; $display("FAIL full_alloc_ignored: full=%b free_pos=%0d expected 1/0",
                            rob_bus.ROB_full, rob_bus.ROB_free_pos);
      end
      cdb(5'd0, 32'h11, 1'b0, 32'h0);
      // Head retires on this edge; the allocate in the same cycle sees full.
      alloc(TYPE_ALU, 5'd7, 32'h84, 1'b0);
      checks++;
      if ({rob_bus.ROB_full, rob_bus.ROB_free_pos} !== {1'b0, 5'd0}) begin
         errors++; $display("FAIL full_same_cycle_slot: full=%b free_pos=%0d expected 0/0",
                            rob_bus.ROB_full, rob_bus.ROB_free_pos);
      end
      checks++;
      if ({rob_bus.ROB_write_S, rob_bus.ROB_Reorder, rob_bus.ROB_result} !== {1'b0, 5'd0, 32'h11}) begin
         errors++; $display("FAIL full_commit_rd0: write=%b tag=%0d result=%h expected 0/0/11",
                            rob_bus.ROB_write_S, rob_bus.ROB_Reorder, rob_bus.ROB_result);
      end
      alloc(TYPE_ALU, 5'd7, 32'h84, 1'b0);
      checks++;
      if ({rob_bus.ROB_full, rob_bus.ROB_free_pos} !== {1'b1, 5'd1}) begin
         errors++; $display("FAIL wrap_tag0_reused: full=%b free_pos=%0d expected 1/1",
                            rob_bus.ROB_full, rob_bus.ROB_free_pos);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_branch();
      do_reset();
      alloc(TYPE_BRANCH, 5'd0, 32'h40, 1'b0);
      alloc(TYPE_ALU, 5'd3, 32'h44, 1'b0);
      cdb(5'd0, 32'h0, 1'b1, 32'h100);
      checks++;
      if (rob_bus.clr !== 1'b0) begin
         errors++; $display("FAIL branch_clr_early: clr=%b expected 0", rob_bus.clr);
      end
      tick();
      checks++;
      if ({rob_bus.clr, rob_bus.clr_pc, rob_bus.ROB_write_S} !== {1'b1, 32'h100, 1'b0}) begin
         errors++; $display("FAIL branch_mispredict: clr=%b clr_pc=%h write=%b expected 1/00000100/0",
                            rob_bus.clr, rob_bus.clr_pc, rob_bus.ROB_write_S);
      end
      // Allocate during the flush cycle must be dropped.
      alloc(TYPE_ALU, 5'd4, 32'h48, 1'b0);
      checks++;
      if ({rob_bus.clr, rob_bus.ROB_free_pos, rob_bus.ROB_full} !== {1'b0, 5'd0, 1'b0}) begin
         errors++; $display("FAIL branch_flush_state: clr=%b free_pos=%0d full=%b expected 0/0/0",
                            rob_bus.clr, rob_bus.ROB_free_pos, rob_bus.ROB_full);
      end

      // Predicted taken, resolved not taken: redirect to pc+4.
      alloc(TYPE_BRANCH, 5'd0, 32'h80, 1'b1);
      cdb(5'd0, 32'h0, 1'b0, 32'h500);
      tick();
      checks++;
      if ({rob_bus.clr, rob_bus.clr_pc} !== {1'b1, 32'h84}) begin
         errors++; $display("FAIL branch_fallthrough: clr=%b clr_pc=%h expected 1/00000084",
                            rob_bus.clr, rob_bus.clr_pc);
      end
      tick();

      // Correctly predicted branch: no flush, no register write.
      alloc(TYPE_BRANCH, 5'd0, 32'h10, 1'b1);
      cdb(5'd0, 32'h0, 1'b1, 32'h900);
      tick();
      checks++;
      if ({rob_bus.clr, rob_bus.ROB_write_S, rob_bus.ROB_Reorder, rob_bus.ROB_free_pos}
          !== {1'b0, 1'b0, 5'd0, 5'd1}) begin
         errors++; $display("FAIL branch_correct: clr=%b write=%b tag=%0d free_pos=%0d expected 0/0/0/1",
                            rob_bus.clr, rob_bus.ROB_write_S, rob_bus.ROB_Reorder, rob_bus.ROB_free_pos);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_jump();
      do_reset();
      alloc(TYPE_JUMP, 5'd1, 32'h20, 1'b0);
      cdb(5'd0, 32'h44, 1'b1, 32'h300);
      tick();
      checks++;
      if ({rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_result, rob_bus.clr, rob_bus.clr_pc}
          !== {1'b1, 5'd1, 32'h44, 1'b1, 32'h300}) begin
         errors++; $display("FAIL jump_mispredict_link: write=%b rd=%0d result=%h clr=%b clr_pc=%h expected 1/1/44/1/300",
                            rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_result, rob_bus.clr, rob_bus.clr_pc);
      end
      tick();
      checks++;
      if ({rob_bus.clr, rob_bus.ROB_write_S, rob_bus.ROB_free_pos} !== {1'b0, 1'b0, 5'd0}) begin
         errors++; $display("FAIL jump_after_flush: clr=%b write=%b free_pos=%0d expected 0/0/0",
                            rob_bus.clr, rob_bus.ROB_write_S, rob_bus.ROB_free_pos);
      end
      alloc(TYPE_JUMP, 5'd2, 32'h30, 1'b1);
      cdb(5'd0, 32'h48, 1'b1, 32'h600);
      tick();
      checks++;
      if ({rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_result, rob_bus.clr}
          !== {1'b1, 5'd2, 32'h48, 1'b0}) begin
         errors++; $display("FAIL jump_predicted: write=%b rd=%0d result=%h clr=%b expected 1/2/48/0",
                            rob_bus.ROB_write_S, rob_bus.ROB_rd, rob_bus.ROB_result, rob_bus.clr);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_query();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc(TYPE_ALU, 5'(i + 1), 32'(i * 4), 1'b0);
      end
      rob_bus.Query1_pos = 5'd3;
      rob_bus.Query2_pos = 5'd5;
      #1;
      checks++;
      if (rob_bus.Query1_ready !== 1'b0) begin
         errors++; $display("FAIL query_not_ready: ready=%b expected 0", rob_bus.Query1_ready);
      end
      rob_bus.CDB_S       = 1'b1;
      rob_bus.CDB_Reorder = 5'd3;
      rob_bus.CDB_value   = 32'd9;
      #1;
      checks++;
      if ({rob_bus.Query1_ready, rob_bus.Query1_value} !== {1'b1, 32'd9}) begin
         errors++; $display("FAIL query_cdb_bypass: ready=%b value=%0d expected 1/9",
                            rob_bus.Query1_ready, rob_bus.Query1_value);
      end
      checks++;
      if (rob_bus.Query2_ready !== 1'b0) begin
         errors++; $display("FAIL query_invalid_tag: ready=%b expected 0", rob_bus.Query2_ready);
      end
      tick();
      rob_bus.CDB_S       = 1'b1;
      rob_bus.CDB_Reorder = 5'd5;
      rob_bus.CDB_value   = 32'd77;
      #1;
      checks++;
      if ({rob_bus.Query1_ready, rob_bus.Query1_value} !== {1'b1, 32'd9}) begin
         errors++; $display("FAIL query_stored: ready=%b value=%0d expected 1/9",
                            rob_bus.Query1_ready, rob_bus.Query1_value);
      end
      checks++;
      if (rob_bus.Query2_ready !== 1'b0) begin
         errors++; $display("FAIL query_invalid_cdb: ready=%b expected 0", rob_bus.Query2_ready);
      end
      idle_inputs();
   endtask

   // ------------------------------------------------------------------
   task automatic test_stall_store();
      do_reset();
      alloc(TYPE_ALU, 5'd0, 32'h0, 1'b0);
      alloc(TYPE_STORE, 5'd0, 32'h4, 1'b0);
      cdb(5'd0, 32'h5, 1'b0, 32'h0);
      tick();                      // tag0 retires here
      rdy                 = 1'b0;
      rob_bus.CDB_S       = 1'b1;
      rob_bus.CDB_Reorder = 5'd1;
      rob_bus.CDB_value   = 32'hABC;
      rob_bus.Dispatch_alloc_S = 1'b1;
      tick();
      tick();
      checks++;
      if ({rob_bus.ROB_store_S, rob_bus.ROB_free_pos} !== {1'b0, 5'd2}) begin
         errors++; $display("FAIL stall_frozen: store=%b free_pos=%0d expected 0/2",
                            rob_bus.ROB_store_S, rob_bus.ROB_free_pos);
      end
      rob_bus.Dispatch_alloc_S = 1'b0;
      rdy = 1'b1;
      tick();                      // writeback lands
      rob_bus.CDB_S = 1'b0;
      checks++;
      if (rob_bus.ROB_store_S !== 1'b0) begin
         errors++; $display("FAIL stall_store_early: store=%b expected 0", rob_bus.ROB_store_S);
      end
      tick();                      // store retires
      checks++;
      if ({rob_bus.ROB_store_S, rob_bus.ROB_Reorder, rob_bus.ROB_write_S} !== {1'b1, 5'd1, 1'b0}) begin
         errors++; $display("FAIL store_release: store=%b tag=%0d write=%b expected 1/1/0",
                            rob_bus.ROB_store_S, rob_bus.ROB_Reorder, rob_bus.ROB_write_S);
      end
      rdy = 1'b0;
      tick();
      checks++;
      if (rob_bus.ROB_store_S !== 1'b1) begin
         errors++; $display("FAIL stall_pulse_hold: store=%b expected 1", rob_bus.ROB_store_S);
      end
      rdy = 1'b1;
      tick();
      checks++;
      if (rob_bus.ROB_store_S !== 1'b0) begin
         errors++; $display("FAIL store_single_pulse: store=%b expected 0", rob_bus.ROB_store_S);
      end
   endtask

   // ------------------------------------------------------------------
   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      rdy    = 1'b1;
      idle_inputs();
      test_reset();
      test_in_order_commit();
      test_full_wrap();
      test_branch();
      test_jump();
      test_query();
      test_stall_store();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
